// File: rtl/pc_gen_bp.sv
// pc_gen_bp: registered fetch PC generator with a 2-bit-counter BHT predictor.
// Optional return address stack enabled by defining PC_GEN_RAS_EN.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   stall              issue queue full, hold the PC
//   fetch_instr        instruction at pc_out
//   pc_out, pred_taken fetch PC and its prediction
//   commit_*           ROB head commit / training inputs
//   mispredicted       combinational flush on a wrongly predicted commit
// RAS_DEPTH must be a power of 2 when PC_GEN_RAS_EN is defined.
module pc_gen_bp #(
    parameter int          XLEN        = 32,
    parameter int          BHT_ENTRIES = 64,
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter logic [1:0]  CTR_INIT    = 2'b01,
    parameter int          RAS_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [31:0]     fetch_instr,
    output logic [XLEN-1:0] pc_out,
    output logic            pred_taken,
    input  logic            commit_valid,
    input  logic            commit_is_branch,
    input  logic [XLEN-1:0] commit_pc,
    input  logic [XLEN-1:0] commit_imm_se,
    input  logic            commit_pred_taken,
    input  logic            commit_result,
    output logic            mispredicted
);

    localparam int IW = $clog2(BHT_ENTRIES);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] b_imm;
    logic [XLEN-1:0] j_imm;
    logic [XLEN-1:0] redirect_pc;
    logic [1:0]      bht [BHT_ENTRIES];
    logic [1:0]      ctr_rd;
    logic [IW-1:0]   fetch_idx;
    logic [IW-1:0]   commit_idx;
    logic            is_br;
    logic            is_jal;
    logic            is_jalr;
    logic            br_taken;
    logic            train;

    assign is_br   = fetch_instr[6:0] == 7'b1100011;
    assign is_jal  = fetch_instr[6:0] == 7'b1101111;
    assign is_jalr = fetch_instr[6:0] == 7'b1100111;

    assign b_imm = {{(XLEN-12){fetch_instr[31]}}, fetch_instr[7],
                    fetch_instr[30:25], fetch_instr[11:8], 1'b0};
    assign j_imm = {{(XLEN-20){fetch_instr[31]}}, fetch_instr[19:12],
                    fetch_instr[20], fetch_instr[30:21], 1'b0};

    assign fetch_idx  = pc_q[IW+1:2];
    assign commit_idx = commit_pc[IW+1:2];
    assign ctr_rd     = bht[fetch_idx];
    assign br_taken   = is_br & ctr_rd[1];
    assign pc_plus4   = pc_q + XLEN'(4);

    assign train        = commit_valid & commit_is_branch;
    assign mispredicted = train & (commit_pred_taken ^ commit_result);
    assign redirect_pc  = commit_pc + (commit_result ? commit_imm_se : XLEN'(4));

`ifdef PC_GEN_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]   ras_wp;
    logic [CW-1:0]   ras_cnt;
    logic [XLEN-1:0] ras_top;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic            rd_link;
    logic            rs1_link;
    logic            ras_hit;
    logic            ras_push;
    logic            ras_pop;

    assign rd       = fetch_instr[11:7];
    assign rs1      = fetch_instr[19:15];
    assign rd_link  = (rd == 5'd1) | (rd == 5'd5);
    assign rs1_link = (rs1 == 5'd1) | (rs1 == 5'd5);
    assign ras_top  = ras[ras_wp - 1'b1];
    // Return prediction only when the stack actually holds an address.
    assign ras_hit  = is_jalr & (rd == 5'd0) & rs1_link & (ras_cnt != '0);
    assign ras_push = ~stall & ~mispredicted & (is_jal | is_jalr) & rd_link;
    assign ras_pop  = ~stall & ~mispredicted & ras_hit;

    assign pred_taken = br_taken | is_jal | ras_hit;

    always_ff @(posedge clk) begin
        if (rst || mispredicted) begin
            ras_wp  <= '0;
            ras_cnt <= '0;
        end else if (ras_push) begin
            // Circular write: a full stack silently drops its oldest entry.
            ras_wp <= ras_wp + 1'b1;
            if (ras_cnt != CW'(RAS_DEPTH))
                ras_cnt <= ras_cnt + 1'b1;
        end else if (ras_pop) begin
            ras_wp  <= ras_wp - 1'b1;
            ras_cnt <= ras_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && ras_push)
            ras[ras_wp] <= pc_plus4;
    end
`else
    assign pred_taken = br_taken | is_jal;
`endif

    always_comb begin
        pc_next = pc_plus4;
        if (mispredicted)
            pc_next = redirect_pc;
        else if (stall)
            pc_next = pc_q;
        else if (br_taken)
            pc_next = pc_q + b_imm;
        else if (is_jal)
            pc_next = pc_q + j_imm;
`ifdef PC_GEN_RAS_EN
        else if (ras_hit)
            pc_next = ras_top;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst)
            pc_q <= XLEN'(RESET_PC);
        else
            pc_q <= pc_next;
    end

    // Predictions read the pre-update counter; updates land at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht[i] <= CTR_INIT;
        end else if (train) begin
            if (commit_result) begin
                if (bht[commit_idx] != 2'b11)
                    bht[commit_idx] <= bht[commit_idx] + 2'b01;
            end else begin
                if (bht[commit_idx] != 2'b00)
                    bht[commit_idx] <= bht[commit_idx] - 2'b01;
            end
        end
    end

    assign pc_out = pc_q;

endmodule

// File: tb/tb_pc_gen_bp.sv
// tb_pc_gen_bp: directed checks of PC sequencing, BHT training and redirects.
// Expected values are hand-computed constants.
module tb_pc_gen_bp;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] BEQ_P20 = 32'h0200_0063;
    localparam logic [31:0] JAL_X1  = 32'h2000_00EF;
    localparam logic [31:0] JALR_RT = 32'h0000_8067;
    localparam logic [31:0] J_M256  = 32'hF01F_F06F;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] fetch_instr;
    logic [31:0] pc_out;
    logic        pred_taken;
    logic        commit_valid;
    logic        commit_is_branch;
    logic [31:0] commit_pc;
    logic [31:0] commit_imm_se;
    logic        commit_pred_taken;
    logic        commit_result;
    logic        mispredicted;

    int checks = 0;
    int errors = 0;

    pc_gen_bp dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .fetch_instr       (fetch_instr),
        .pc_out            (pc_out),
        .pred_taken        (pred_taken),
        .commit_valid      (commit_valid),
        .commit_is_branch  (commit_is_branch),
        .commit_pc         (commit_pc),
        .commit_imm_se     (commit_imm_se),
        .commit_pred_taken (commit_pred_taken),
        .commit_result     (commit_result),
        .mispredicted      (mispredicted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [31:0] pc, input logic pred,
                          input logic res, input logic [31:0] imm);
        commit_valid      = 1'b1;
        commit_is_branch  = 1'b1;
        commit_pc         = pc;
        commit_pred_taken = pred;
        commit_result     = res;
        commit_imm_se     = imm;
    endtask

    task automatic no_commit();
        commit_valid      = 1'b0;
        commit_is_branch  = 1'b0;
        commit_pc         = '0;
        commit_pred_taken = 1'b0;
        commit_result     = 1'b0;
        commit_imm_se     = '0;
    endtask

    initial begin
        logic [31:0] ret_pc;
        logic        ret_pred;
`ifdef PC_GEN_RAS_EN
        ret_pc   = 32'h104;
        ret_pred = 1'b1;
`else
        ret_pc   = 32'h304;
        ret_pred = 1'b0;
`endif
        rst = 1'b1;
        stall = 1'b0;
        fetch_instr = NOP;
        no_commit();
        step();
        step();
        check("rst_pc", pc_out, 32'h0);
        check("rst_pred", {31'b0, pred_taken}, 32'h0);
        check("rst_mispred", {31'b0, mispredicted}, 32'h0);
        rst = 1'b0;
        step();
        check("seq_4", pc_out, 32'h4);
        step();
        check("seq_8", pc_out, 32'h8);
        step();
        check("seq_c", pc_out, 32'hC);
        step();
        check("seq_10", pc_out, 32'h10);

        // BEQ at 0x10 with same-cycle training: old counter is used
        fetch_instr = BEQ_P20;
        commit(32'h10, 1'b1, 1'b1, 32'h20);
        #1;
        check("beq_cold_pred", {31'b0, pred_taken}, 32'h0);
        check("beq_cold_nomis", {31'b0, mispredicted}, 32'h0);
        step();
        check("beq_cold_next", pc_out, 32'h14);
        fetch_instr = NOP;
        step();
        commit(32'hC, 1'b1, 1'b0, 32'h0);
        #1;
        check("redir_mispred", {31'b0, mispredicted}, 32'h1);
        step();
        no_commit();
        check("redir_pc", pc_out, 32'h10);
        fetch_instr = BEQ_P20;
        #1;
        check("beq_warm_pred", {31'b0, pred_taken}, 32'h1);
        step();
        check("beq_warm_next", pc_out, 32'h30);

        // mispredict wins over stall
        fetch_instr = NOP;
        stall = 1'b1;
        commit(32'h40, 1'b1, 1'b0, 32'h8);
        #1;
        check("stall_mispred", {31'b0, mispredicted}, 32'h1);
        step();
        check("stall_redir", pc_out, 32'h44);
        no_commit();
        step();
        check("stall_hold", pc_out, 32'h44);
        stall = 1'b0;

        // saturation at 3: 5 taken, 1 not-taken -> 2 (taken), another -> 1
        for (int i = 0; i < 5; i++) begin
            commit(32'h80, 1'b1, 1'b1, 32'h20);
            step();
        end
        commit(32'h80, 1'b0, 1'b0, 32'h20);
        step();
        commit(32'h7C, 1'b1, 1'b0, 32'h0);
        step();
        no_commit();
        check("sat3_redir", pc_out, 32'h80);
        fetch_instr = BEQ_P20;
        #1;
        check("sat3_pred", {31'b0, pred_taken}, 32'h1);
        step();
        check("sat3_next", pc_out, 32'hA0);
        fetch_instr = NOP;
        commit(32'h80, 1'b0, 1'b0, 32'h20);
        step();
        commit(32'h7C, 1'b1, 1'b0, 32'h0);
        step();
        no_commit();
        fetch_instr = BEQ_P20;
        #1;
        check("ctr1_pred", {31'b0, pred_taken}, 32'h0);
        step();
        check("ctr1_next", pc_out, 32'h84);

        // saturation at 0 on idx of 0x40 (already 0): dec stays 0, inc -> 1
        fetch_instr = NOP;
        commit(32'h40, 1'b0, 1'b0, 32'h8);
        step();
        commit(32'h40, 1'b1, 1'b1, 32'h8);
        step();
        commit(32'h3C, 1'b1, 1'b0, 32'h0);
        step();
        no_commit();
        fetch_instr = BEQ_P20;
        #1;
        check("sat0_pred", {31'b0, pred_taken}, 32'h0);
        step();
        check("sat0_next", pc_out, 32'h44);

        // JAL / JALR / backward JAL
        fetch_instr = NOP;
        commit(32'hFC, 1'b1, 1'b0, 32'h0);
        step();
        no_commit();
        check("jal_at", pc_out, 32'h100);
        fetch_instr = JAL_X1;
        #1;
        check("jal_pred", {31'b0, pred_taken}, 32'h1);
        step();
        check("jal_next", pc_out, 32'h300);
        fetch_instr = JALR_RT;
        #1;
        check("jalr_pred", {31'b0, pred_taken}, {31'b0, ret_pred});
        step();
        check("jalr_next", pc_out, ret_pc);
        fetch_instr = J_M256;
        step();
        check("jal_back", pc_out, ret_pc - 32'h100);

        // wrap-around
        fetch_instr = NOP;
        commit(32'hFFFF_FFF8, 1'b1, 1'b0, 32'h0);
        step();
        no_commit();
        check("wrap_at", pc_out, 32'hFFFF_FFFC);
        step();
        check("wrap_next", pc_out, 32'h0);
        commit(32'hFFFF_FFF0, 1'b0, 1'b1, 32'h20);
        step();
        check("wrap_redir", pc_out, 32'h10);

        // mispredict qualifiers
        commit(32'h200, 1'b1, 1'b0, 32'h0);
        commit_valid = 1'b0;
        #1;
        check("noval_mispred", {31'b0, mispredicted}, 32'h0);
        commit_valid = 1'b1;
        commit_is_branch = 1'b0;
        #1;
        check("nobr_mispred", {31'b0, mispredicted}, 32'h0);

        // reset overrides a redirect
        commit_is_branch = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        no_commit();
        check("rst_mid_pc", pc_out, 32'h0);
        fetch_instr = BEQ_P20;
        #1;
        check("rst_mid_pred", {31'b0, pred_taken}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
